// File: rtl/input_line_buffer_mc_pkg.sv
// Shared defaults, 3x3 tap indices and FSM encoding for the multi-channel
// 3x3 window generator.
package input_line_buffer_mc_pkg;

    localparam int DATA_WIDTH_DEF     = 16;
    localparam int LANES_DEF          = 16;
    localparam int MAX_IMAGE_SIZE_DEF = 64;
    localparam int SIZE_W_DEF         = 8;

    // tap k = 3*row + col, row 0 is the top of the window
    localparam int TAP_00 = 0;
    localparam int TAP_01 = 1;
    localparam int TAP_02 = 2;
    localparam int TAP_10 = 3;
    localparam int TAP_11 = 4;
    localparam int TAP_12 = 5;
    localparam int TAP_20 = 6;
    localparam int TAP_21 = 7;
    localparam int TAP_22 = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/input_line_buffer_mc_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// A read of the address being written returns the old contents.
module input_line_buffer_mc_line_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 256,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/input_line_buffer_mc.sv
// Multi-channel 3x3 "same"-padded window generator. Two line RAMs hold the
// previous two rows; the live beat supplies the bottom row of each window.
module input_line_buffer_mc
    import input_line_buffer_mc_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int LANES          = LANES_DEF,
    parameter int MAX_IMAGE_SIZE = MAX_IMAGE_SIZE_DEF,
    parameter int SIZE_W         = SIZE_W_DEF
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          start,
    input  logic [SIZE_W-1:0]             IMAGE_SIZE,
    input  logic                          stride2,
    input  logic [LANES*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [9*LANES*DATA_WIDTH-1:0] out_window,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          Done_1row,
    output logic                          Done_frame,
    output logic                          protocol_err
);

    localparam int BW = LANES * DATA_WIDTH;
    localparam int AW = (MAX_IMAGE_SIZE > 1) ? $clog2(MAX_IMAGE_SIZE) : 1;

    typedef struct packed {
        logic [BW-1:0] top;
        logic [BW-1:0] mid;
        logic [BW-1:0] bot;
    } col_t;

    state_e            state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] row_q, row_d;
    logic [SIZE_W-1:0] col_q, col_d;
    logic              stride2_q, stride2_d;
    logic              insert_q, insert_d;
    logic              err_q, err_d;
    col_t              ca_q, ca_d;
    col_t              cb_q, cb_d;
    logic [9*BW-1:0]   win_q, win_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;

    logic [BW-1:0]     ram_a_rd, ram_b_rd;
    logic              can_load, in_phase, tready, accept, flush_step, step, ins_step;
    logic              last_col, last_beat, emit_pos, stride_ok, emit;
    logic [SIZE_W-1:0] win_r, win_c, last_c;
    col_t              new_col, left, right;
    logic [9*BW-1:0]   win_w;

    assign can_load   = !vld_q || out_ready;
    assign in_phase   = (state_q == ST_FILL) || (state_q == ST_STREAM);
    assign tready     = in_phase && !insert_q && can_load;
    assign accept     = s_axis_tvalid && tready;
    assign flush_step = (state_q == ST_FLUSH) && !insert_q && can_load;
    assign step       = accept || flush_step;
    assign ins_step   = insert_q && can_load;
    assign last_col   = (col_q == size_q - SIZE_W'(1));
    assign last_beat  = (row_q == size_q - SIZE_W'(1)) && last_col;

    // Top padding comes from masking, so stale RAM contents never leak into row 0
    assign new_col.top = (row_q == SIZE_W'(1)) ? '0 : ram_b_rd;
    assign new_col.mid = ram_a_rd;
    assign new_col.bot = (state_q == ST_FLUSH) ? '0 : s_axis_tdata;

    assign win_r     = row_q - SIZE_W'(1);
    assign win_c     = step ? (col_q - SIZE_W'(1)) : (size_q - SIZE_W'(1));
    assign emit_pos  = (step && (col_q != '0) && (state_q != ST_FILL)) || ins_step;
    assign stride_ok = !stride2_q || (!win_r[0] && !win_c[0]);
    assign emit      = emit_pos && stride_ok;
    assign last_c    = (stride2_q && !size_q[0]) ? (size_q - SIZE_W'(2)) : (size_q - SIZE_W'(1));

    assign left  = (!insert_q && (col_q == SIZE_W'(1))) ? '0 : ca_q;
    assign right = insert_q ? '0 : new_col;

    always_comb begin
        win_w = '0;
        win_w[TAP_00*BW +: BW] = left.top;
        win_w[TAP_01*BW +: BW] = cb_q.top;
        win_w[TAP_02*BW +: BW] = right.top;
        win_w[TAP_10*BW +: BW] = left.mid;
        win_w[TAP_11*BW +: BW] = cb_q.mid;
        win_w[TAP_12*BW +: BW] = right.mid;
        win_w[TAP_20*BW +: BW] = left.bot;
        win_w[TAP_21*BW +: BW] = cb_q.bot;
        win_w[TAP_22*BW +: BW] = right.bot;
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        stride2_d = stride2_q;
        row_d     = row_q;
        col_d     = col_q;
        insert_d  = insert_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d    = IMAGE_SIZE;
                    stride2_d = stride2;
                    err_d     = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    insert_d  = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (last_col) begin
                        col_d   = '0;
                        row_d   = SIZE_W'(1);
                        state_d = ST_STREAM;
                    end else begin
                        col_d = col_q + SIZE_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (ins_step) begin
                    insert_d = 1'b0;
                    row_d    = row_q + SIZE_W'(1);
                    if (row_q == size_q - SIZE_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end else if (accept) begin
                    if (last_col) begin
                        col_d    = '0;
                        insert_d = 1'b1;
                    end else begin
                        col_d = col_q + SIZE_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (ins_step) begin
                    insert_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (flush_step) begin
                    if (last_col) begin
                        col_d    = '0;
                        insert_d = 1'b1;
                    end else begin
                        col_d = col_q + SIZE_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept && (s_axis_tlast != last_beat)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        ca_d   = ca_q;
        cb_d   = cb_q;
        win_d  = win_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (step) begin
            ca_d = cb_q;
            cb_d = new_col;
        end
        if (can_load) begin
            vld_d = emit;
            if (emit) begin
                win_d  = win_w;
                last_d = (win_c == last_c);
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            size_q    <= '0;
            stride2_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            insert_q  <= 1'b0;
            err_q     <= 1'b0;
            ca_q      <= '0;
            cb_q      <= '0;
            win_q     <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            stride2_q <= stride2_d;
            row_q     <= row_d;
            col_q     <= col_d;
            insert_q  <= insert_d;
            err_q     <= err_d;
            ca_q      <= ca_d;
            cb_q      <= cb_d;
            win_q     <= win_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    // Read address follows the next column so read data lines up with the beat
    input_line_buffer_mc_line_ram #(.DEPTH(MAX_IMAGE_SIZE), .WIDTH(BW), .AW(AW)) u_ram_a (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (col_q[AW-1:0]),
        .wdata_i (s_axis_tdata),
        .raddr_i (col_d[AW-1:0]),
        .rdata_o (ram_a_rd)
    );

    input_line_buffer_mc_line_ram #(.DEPTH(MAX_IMAGE_SIZE), .WIDTH(BW), .AW(AW)) u_ram_b (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (col_q[AW-1:0]),
        .wdata_i (ram_a_rd),
        .raddr_i (col_d[AW-1:0]),
        .rdata_o (ram_b_rd)
    );

    assign s_axis_tready = tready;
    assign out_window    = win_q;
    assign out_valid     = vld_q;
    assign Done_1row     = vld_q && out_ready && last_q;
    assign Done_frame    = (state_q == ST_DONE);
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_input_line_buffer_mc.sv
// Scoreboard bench for the 3x3 window generator: expected windows are queued
// as each frame is driven and compared tap by tap on every output handshake.
module tb_input_line_buffer_mc;

    localparam int DW   = 16;
    localparam int LN   = 16;
    localparam int MAXN = 64;
    localparam int SW   = 8;
    localparam int BW   = LN * DW;

    logic              clk = 1'b0;
    logic              Reset = 1'b0;
    logic              start = 1'b0;
    logic [SW-1:0]     isz = '0;
    logic              stride2 = 1'b0;
    logic [BW-1:0]     tdata = '0;
    logic              tvalid = 1'b0;
    logic              tlast = 1'b0;
    logic              tready;
    logic [9*BW-1:0]   out_window;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              done_row, done_frame, perr;

    input_line_buffer_mc #(
        .DATA_WIDTH(DW), .LANES(LN), .MAX_IMAGE_SIZE(MAXN), .SIZE_W(SW)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .start         (start),
        .IMAGE_SIZE    (isz),
        .stride2       (stride2),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .out_window    (out_window),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Done_1row     (done_row),
        .Done_frame    (done_frame),
        .protocol_err  (perr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    typedef struct {
        int   r;
        int   c;
        int   n;
        logic last;
    } exp_t;

    exp_t sb[$];

    function automatic logic [DW-1:0] pix(int r, int c, int n, int l);
        if (r < 0 || r >= n || c < 0 || c >= n) return '0;
        return DW'(r * n + c + 1 + 256 * l);
    endfunction

    function automatic logic [BW-1:0] beat(int r, int c, int n);
        logic [BW-1:0] t;
        t = '0;
        for (int l = 0; l < LN; l++) t[l*DW +: DW] = pix(r, c, n, l);
        return t;
    endfunction

    function automatic logic [BW-1:0] exp_tap(int r, int c, int n, int k);
        logic [BW-1:0] t;
        t = '0;
        for (int l = 0; l < LN; l++) t[l*DW +: DW] = pix(r - 1 + k / 3, c - 1 + k % 3, n, l);
        return t;
    endfunction

    int            win_seen = 0;
    int            rows_seen = 0;
    int            frames_seen = 0;
    bit            rand_ready = 1'b0;
    bit            hold_pending = 1'b0;
    logic [9*BW-1:0] held_win = '0;
    exp_t          e_mon;

    always @(negedge clk) begin
        if (Reset) begin
            if (hold_pending) begin
                chk("hold_valid", BW'(out_valid), 1);
                chk("hold_data", BW'(out_window == held_win), 1);
            end
            if (out_valid && !out_ready) begin
                chk("stall_tready", BW'(tready), 0);
                hold_pending = 1'b1;
                held_win     = out_window;
            end else begin
                hold_pending = 1'b0;
            end
            if (done_row) rows_seen++;
            if (done_frame) frames_seen++;
            if (out_valid && out_ready) begin
                win_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                end else begin
                    e_mon = sb.pop_front();
                    for (int k = 0; k < 9; k++)
                        chk($sformatf("win r%0d c%0d tap%0d", e_mon.r, e_mon.c, k),
                            out_window[k*BW +: BW], exp_tap(e_mon.r, e_mon.c, e_mon.n, k));
                    chk($sformatf("done_1row r%0d c%0d", e_mon.r, e_mon.c), BW'(done_row), BW'(e_mon.last));
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_frame(input int n, input bit s2, input bit gaps, input int tlast_beat, input int nbeats);
        int lastc;
        int guard;
        lastc = s2 ? (((n - 1) % 2 == 0) ? n - 1 : n - 2) : n - 1;
        win_seen    = 0;
        rows_seen   = 0;
        frames_seen = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (!s2 || (r % 2 == 0 && c % 2 == 0))
                    sb.push_back('{r: r, c: c, n: n, last: (c == lastc)});
        @(posedge clk); #1;
        start   = 1'b1;
        isz     = SW'(n);
        stride2 = s2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            tvalid = 1'b1;
            tdata  = beat(b / n, b % n, n);
            tlast  = (b == tlast_beat);
            guard  = 0;
            forever begin
                @(negedge clk);
                if (tready) break;
                guard++;
                if (guard > 5000) begin
                    chk("tready_timeout", 0, 1);
                    tvalid = 1'b0;
                    tlast  = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_frame(input int n, input bit s2, input bit exp_err);
        int guard;
        guard = 0;
        while ((frames_seen == 0 || sb.size() != 0) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        chk("frame_timeout", BW'(guard < 20000), 1);
        chk("done_frame_cnt", BW'(frames_seen), 1);
        chk("window_cnt", BW'(win_seen), BW'(s2 ? n * n / 4 : n * n));
        chk("row_cnt", BW'(rows_seen), BW'(s2 ? n / 2 : n));
        chk("protocol_err", BW'(perr), BW'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", BW'(out_valid), 0);
        chk("rst_tready", BW'(tready), 0);
        chk("rst_window", BW'(out_window != '0), 0);
        chk("rst_done_frame", BW'(done_frame), 0);
        chk("rst_done_row", BW'(done_row), 0);
        chk("rst_perr", BW'(perr), 0);
        Reset = 1'b1;

        // basic frame, always ready
        send_frame(4, 1'b0, 1'b0, 15, 16);
        wait_frame(4, 1'b0, 1'b0);

        // backpressure and source gaps
        rand_ready = 1'b1;
        send_frame(4, 1'b0, 1'b1, 15, 16);
        wait_frame(4, 1'b0, 1'b0);
        rand_ready = 1'b0;

        // stride 2
        send_frame(4, 1'b1, 1'b0, 15, 16);
        wait_frame(4, 1'b1, 1'b0);
        rand_ready = 1'b1;
        send_frame(6, 1'b1, 1'b1, 35, 36);
        wait_frame(6, 1'b1, 1'b0);

        // other sizes, including the smallest, an odd one and the largest
        send_frame(8, 1'b0, 1'b1, 63, 64);
        wait_frame(8, 1'b0, 1'b0);
        send_frame(3, 1'b0, 1'b1, 8, 9);
        wait_frame(3, 1'b0, 1'b0);
        send_frame(2, 1'b0, 1'b0, 3, 4);
        wait_frame(2, 1'b0, 1'b0);
        rand_ready = 1'b0;
        send_frame(MAXN, 1'b0, 1'b0, MAXN * MAXN - 1, MAXN * MAXN);
        wait_frame(MAXN, 1'b0, 1'b0);

        // reset in the middle of row 2
        send_frame(4, 1'b0, 1'b0, 15, 9);
        #1;
        Reset = 1'b0;
        #1;
        chk("abort_valid", BW'(out_valid), 0);
        chk("abort_window", BW'(out_window != '0), 0);
        chk("abort_tready", BW'(tready), 0);
        chk("abort_done_frame", BW'(done_frame), 0);
        chk("abort_perr", BW'(perr), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b1;
        send_frame(2, 1'b0, 1'b0, 3, 4);
        wait_frame(2, 1'b0, 1'b0);

        // early tlast, then a clean frame clears the sticky error
        send_frame(4, 1'b0, 1'b0, 10, 16);
        wait_frame(4, 1'b0, 1'b1);
        send_frame(4, 1'b0, 1'b0, 15, 16);
        wait_frame(4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
